tile_hit_judge: RTL and testbench
=================================

# tile_hit_judge

Downstream consumer of the falling-tile position generator: each frame it takes the tile's X/Y/size and the current USB keycode and decides whether the player hit the tile, missed it, or pressed the wrong key. It keeps a 4-digit BCD score, a miss counter and a game state, and drives the score/flash/game-over signals read by the colour mapper and the hex displays. All state updates once per frame.

## Interface
- NUM_LANES, 4: lanes, each 160 px wide (X 0-159, 160-319, 320-479, 480-639).
- HIT_Y_MIN, 360: top of hit window; tile bottom edge compared.
- HIT_Y_MAX, 479: bottom of hit window, inclusive.
- MAX_MISSES, 3: misses that end the game (1-3).
- FLASH_FRAMES, 8: frames HitFlash stays high after a hit.
- frame_clk  in  1  the only clock; the vertical-sync frame tick.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  8  USB HID keycode, 0 = no key.
- TileX  in  10  tile centre X from the tile generator.
- TileY  in  10  tile centre Y from the tile generator.
- TileS  in  10  tile half-size from the tile generator.
- Score  out  16  4-digit BCD score, digit 3 in [15:12].
- Misses  out  2  miss count.
- HitFlash  out  1  high for FLASH_FRAMES frames after a hit.
- GameOver  out  1  high in OVER state.
- Lane  out  2  registered lane index of the current tile.

## Operation
- FSM states IDLE, PLAY, OVER; reset -> IDLE, Score=0, Misses=0, HitFlash=0, GameOver=0, Lane=0, all internal flags 0.
- Key press = keycode != 0 and keycode != previous-frame keycode (key_prev register, updated every frame in every state).
- Lane keys: 0x04 (A) lane 0, 0x16 (S) lane 1, 0x07 (D) lane 2, 0x09 (F) lane 3; any other nonzero code is a non-lane key.
- IDLE: any press -> PLAY; that press is not judged.
- in_win (combinational) = (TileY + TileS) in [HIT_Y_MIN, HIT_Y_MAX]; 10-bit unsigned sum, carry out treated as out of window.
- entry = in_win & !in_win_prev. pending set on entry, cleared on hit or exit.
- Hit: PLAY, lane-key press, key lane == tile lane, in_win, (pending | entry). Score +1 BCD with per-digit carry, saturates at 9999; pending cleared; flash counter loaded with FLASH_FRAMES.
- Exit miss: pending & !in_win -> Misses +1, pending cleared.
- Wrong-key miss: see Configuration.
- At most one miss is counted per frame; a hit and an exit miss cannot happen in the same frame.
- Misses reaching MAX_MISSES -> OVER. OVER freezes Score/Misses/Lane, HitFlash forced 0, GameOver=1; only Reset leaves OVER.
- Tile moving up (bounce) is judged identically; direction is ignored.

## Timing
- All outputs registered. An input sampled at frame edge N is reflected in the outputs after edge N, so latency is 1 frame.
- HitFlash rises after the hit edge and stays high exactly FLASH_FRAMES frames. A new hit during a flash reloads the counter.
- GameOver rises on the same edge that Misses reaches MAX_MISSES.
- Reset asserted mid-game wins over every other event on that edge.

## Configuration
- JUDGE_WRONG_KEY_PENALTY_EN defined: in PLAY, a lane-key press that is not a hit counts one miss. Non-lane keys are still ignored.
- Not defined: presses that are not hits have no effect.
- Exit misses occur in both builds.

## Structure
- Package judge_pkg holds:
  - the state enum (IDLE, PLAY, OVER);
  - the lane keycode constants;
  - the lane boundary constants 160/320/480.
- One sub-module, bcd_counter4: 4-digit saturating BCD incrementer with synchronous clear.

## Test plan
- Reset, then keycode 0x04 for one frame: state goes to PLAY, Score=0x0000, Misses=0.
- TileX=80, TileS=40, TileY stepped 310->330, key 0x04 pressed while TileY=330: Score=0x0001, HitFlash high for 8 frames, no miss when the tile leaves the window.
- TileX=400, tile passes through the window with no key: exactly one miss on the frame TileY+TileS leaves [360,479].
- Score preloaded to 0x0099 by 99 hits, then one more hit: Score=0x0100. At 0x9999, another hit leaves Score=0x9999.
- Three exit misses: GameOver=1 on the third. Further presses change nothing. Reset returns to IDLE with all outputs 0.
- With JUDGE_WRONG_KEY_PENALTY_EN, key 0x07 pressed while the tile is in lane 0 and in the window: Misses +1, Score unchanged. Without the macro, nothing changes. Holding the key over several frames counts once in both builds.

Source files
------------

// File: rtl/judge_pkg.sv
// Shared types and constants for the tile hit judge: game state, lane keycodes, lane boundaries.
package judge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StOver
  } state_e;

  localparam logic [7:0] KeyLane0 = 8'h04;  // A
  localparam logic [7:0] KeyLane1 = 8'h16;  // S
  localparam logic [7:0] KeyLane2 = 8'h07;  // D
  localparam logic [7:0] KeyLane3 = 8'h09;  // F

  localparam logic [9:0] LaneBound1 = 10'd160;
  localparam logic [9:0] LaneBound2 = 10'd320;
  localparam logic [9:0] LaneBound3 = 10'd480;

  function automatic logic [1:0] lane_of_x(input logic [9:0] x);
    if (x < LaneBound1) return 2'd0;
    else if (x < LaneBound2) return 2'd1;
    else if (x < LaneBound3) return 2'd2;
    else return 2'd3;
  endfunction

  function automatic logic is_lane_key(input logic [7:0] key);
    return (key == KeyLane0) || (key == KeyLane1) || (key == KeyLane2) || (key == KeyLane3);
  endfunction

  function automatic logic [1:0] lane_of_key(input logic [7:0] key);
    case (key)
      KeyLane1: return 2'd1;
      KeyLane2: return 2'd2;
      KeyLane3: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/tile_hit_judge_if.sv
// Tile/key inputs and score/status outputs of the hit judge, grouped as one bundle.
interface tile_hit_judge_if;
  logic [7:0]  keycode;
  logic [9:0]  TileX;
  logic [9:0]  TileY;
  logic [9:0]  TileS;
  logic [15:0] Score;
  logic [1:0]  Misses;
  logic        HitFlash;
  logic        GameOver;
  logic [1:0]  Lane;

  modport master (
    output keycode, TileX, TileY, TileS,
    input  Score, Misses, HitFlash, GameOver, Lane
  );

  modport slave (
    input  keycode, TileX, TileY, TileS,
    output Score, Misses, HitFlash, GameOver, Lane
  );
endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD incrementer that saturates at 9999, with synchronous clear.
module bcd_counter4 (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q, count_d;
  logic        carry;

  always_comb begin
    count_d = count_q;
    carry   = inc_i && (count_q != 16'h9999);
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_d[4*i +: 4] = 4'd0;
        end else begin
          count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) count_q <= 16'h0000;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/tile_hit_judge.sv
// Per-frame hit/miss judge for the falling tile game: score, misses, flash and game-over.
// Optional build macro JUDGE_WRONG_KEY_PENALTY_EN makes a wrong lane-key press cost a miss.
module tile_hit_judge
  import judge_pkg::*;
#(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned HIT_Y_MIN    = 360,
  parameter int unsigned HIT_Y_MAX    = 479,
  parameter int unsigned MAX_MISSES   = 3,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input logic              frame_clk,
  input logic              Reset,
  tile_hit_judge_if.slave  bus
);

  localparam int unsigned FlashW   = $clog2(FLASH_FRAMES + 1);
  localparam logic [9:0]  YMin     = 10'(HIT_Y_MIN);
  localparam logic [9:0]  YMax     = 10'(HIT_Y_MAX);
  localparam logic [1:0]  MaxMiss  = 2'(MAX_MISSES);
  localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_FRAMES);
  localparam logic [FlashW-1:0] FlashOne  = FlashW'(1);

  state_e              state_q, state_d;
  logic [7:0]          key_prev_q, key_prev_d;
  logic                in_win_prev_q, in_win_prev_d;
  logic                pending_q, pending_d;
  logic [1:0]          misses_q, misses_d;
  logic [FlashW-1:0]   flash_cnt_q, flash_cnt_d;
  logic                hit_flash_q, hit_flash_d;
  logic [1:0]          lane_q, lane_d;

  logic [10:0] bottom;
  logic        in_win, entry, press, lane_key, hit, exit_miss, wrong_miss, miss, pending_track;
  logic [1:0]  key_lane, tile_lane;
  logic [15:0] score;

  always_comb begin
    // Carry out of the 10-bit sum means the tile is below the screen, never in the window.
    bottom    = {1'b0, bus.TileY} + {1'b0, bus.TileS};
    in_win    = !bottom[10] && (bottom[9:0] >= YMin) && (bottom[9:0] <= YMax);
    entry     = in_win && !in_win_prev_q;
    press     = (bus.keycode != 8'h00) && (bus.keycode != key_prev_q);
    lane_key  = is_lane_key(bus.keycode);
    key_lane  = lane_of_key(bus.keycode);
    tile_lane = lane_of_x(bus.TileX);
    if (NUM_LANES < 4 && 32'(tile_lane) >= NUM_LANES) tile_lane = 2'(NUM_LANES - 1);

    pending_track = in_win && (pending_q || entry);
    hit       = (state_q == StPlay) && press && lane_key && (key_lane == tile_lane) &&
                in_win && (pending_q || entry);
    exit_miss = (state_q == StPlay) && pending_q && !in_win;
`ifdef JUDGE_WRONG_KEY_PENALTY_EN
    wrong_miss = (state_q == StPlay) && press && lane_key && !hit;
`else
    wrong_miss = 1'b0;
`endif
    miss = exit_miss || wrong_miss;
  end

  always_comb begin
    state_d       = state_q;
    key_prev_d    = bus.keycode;
    in_win_prev_d = in_win;
    pending_d     = pending_q;
    misses_d      = misses_q;
    flash_cnt_d   = flash_cnt_q;
    lane_d        = lane_q;

    unique case (state_q)
      StIdle: begin
        lane_d    = tile_lane;
        pending_d = 1'b0;
        if (press) state_d = StPlay;
      end
      StPlay: begin
        lane_d    = tile_lane;
        pending_d = pending_track && !hit;
        if (miss) misses_d = misses_q + 2'd1;
        if (hit) flash_cnt_d = FlashLoad;
        else if (flash_cnt_q != '0) flash_cnt_d = flash_cnt_q - FlashOne;
        if (misses_d == MaxMiss) state_d = StOver;
      end
      StOver: begin
        pending_d   = 1'b0;
        flash_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase

    hit_flash_d = (flash_cnt_d != '0) && (state_d != StOver);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q       <= StIdle;
      key_prev_q    <= 8'h00;
      in_win_prev_q <= 1'b0;
      pending_q     <= 1'b0;
      misses_q      <= 2'd0;
      flash_cnt_q   <= '0;
      hit_flash_q   <= 1'b0;
      lane_q        <= 2'd0;
    end else begin
      state_q       <= state_d;
      key_prev_q    <= key_prev_d;
      in_win_prev_q <= in_win_prev_d;
      pending_q     <= pending_d;
      misses_q      <= misses_d;
      flash_cnt_q   <= flash_cnt_d;
      hit_flash_q   <= hit_flash_d;
      lane_q        <= lane_d;
    end
  end

  bcd_counter4 u_score (
    .clk_i   (frame_clk),
    .clr_i   (Reset),
    .inc_i   (hit),
    .count_o (score)
  );

  assign bus.Score    = score;
  assign bus.Misses   = misses_q;
  assign bus.HitFlash = hit_flash_q;
  assign bus.GameOver = (state_q == StOver);
  assign bus.Lane     = lane_q;

endmodule

// File: tb/tb_tile_hit_judge.sv
// Directed scoreboard bench for tile_hit_judge: driver queues expected outputs per frame,
// a monitor one step after each frame edge pops and compares.
module tb_tile_hit_judge;

  logic frame_clk = 1'b0;
  logic Reset;

  always #5 frame_clk = ~frame_clk;

  tile_hit_judge_if bus ();

  tile_hit_judge dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  typedef struct {
    logic [15:0] score;
    logic [1:0]  misses;
    logic        flash;
    logic        over;
    logic [1:0]  lane;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks   = 0;
  int failures = 0;

  int         e_dec;
  logic [1:0] e_miss;
  logic       e_over;
  logic       was_over;
  int         e_fcnt;
  logic [1:0] e_lane;
  int         frame_no = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req,
                       input int tag);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 25)
        $display("FAIL %s frame=%0d actual=%h required=%h", name, tag, act, req);
    end
  endtask

  function automatic logic [1:0] lane_of(input logic [9:0] x);
    if (x < 10'd160) return 2'd0;
    if (x < 10'd320) return 2'd1;
    if (x < 10'd480) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [15:0] to_bcd(input int d);
    logic [15:0] r;
    int v;
    v = (d > 9999) ? 9999 : d;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // One frame: drive inputs between edges and queue what the outputs must be after the edge.
  task automatic frame(input logic rst, input logic [7:0] key, input logic [9:0] x,
                       input logic [9:0] y, input logic [9:0] s);
    exp_t e;
    @(negedge frame_clk);
    Reset       = rst;
    bus.keycode = key;
    bus.TileX   = x;
    bus.TileY   = y;
    bus.TileS   = s;
    if (rst) begin
      e_dec = 0; e_miss = 2'd0; e_over = 1'b0; e_fcnt = 0; e_lane = 2'd0;
    end else if (!was_over) begin
      e_lane = lane_of(x);
    end
    e.score  = to_bcd(e_dec);
    e.misses = e_miss;
    e.flash  = (e_fcnt != 0) && !e_over;
    e.over   = e_over;
    e.lane   = e_lane;
    e.tag    = frame_no;
    frame_no++;
    exp_q.push_back(e);
    if (e_fcnt != 0) e_fcnt--;
    was_over = e_over;
  endtask

  task automatic hit_frame(input logic [7:0] key, input logic [9:0] x, input logic [9:0] y,
                           input logic [9:0] s);
    e_dec++;
    e_fcnt = 8;
    frame(1'b0, key, x, y, s);
  endtask

  task automatic miss_frame(input logic [7:0] key, input logic [9:0] x, input logic [9:0] y,
                            input logic [9:0] s);
    e_miss = e_miss + 2'd1;
    if (e_miss == 2'd3) begin
      e_over = 1'b1;
      e_fcnt = 0;
    end
    frame(1'b0, key, x, y, s);
  endtask

  always @(posedge frame_clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("score",    bus.Score,                 mon_e.score,                 mon_e.tag);
      check("misses",   {14'd0, bus.Misses},       {14'd0, mon_e.misses},       mon_e.tag);
      check("hitflash", {15'd0, bus.HitFlash},     {15'd0, mon_e.flash},        mon_e.tag);
      check("gameover", {15'd0, bus.GameOver},     {15'd0, mon_e.over},         mon_e.tag);
      check("lane",     {14'd0, bus.Lane},         {14'd0, mon_e.lane},         mon_e.tag);
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog time limit reached frame=%0d", frame_no);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    Reset = 1'b1;
    bus.keycode = 8'h00; bus.TileX = 10'd80; bus.TileY = 10'd0; bus.TileS = 10'd40;
    e_dec = 0; e_miss = 2'd0; e_over = 1'b0; was_over = 1'b0; e_fcnt = 0; e_lane = 2'd0;

    frame(1'b1, 8'h00, 10'd80, 10'd0, 10'd40);
    frame(1'b1, 8'h00, 10'd80, 10'd0, 10'd40);
    frame(1'b0, 8'h00, 10'd80, 10'd0, 10'd40);
    frame(1'b0, 8'h04, 10'd80, 10'd0, 10'd40);     // start game, not judged

    // Lane 0 hit on the way down, window entered exactly at 360
    frame(1'b0, 8'h00, 10'd80, 10'd310, 10'd40);
    frame(1'b0, 8'h00, 10'd80, 10'd320, 10'd40);
    hit_frame(8'h04, 10'd80, 10'd330, 10'd40);
    frame(1'b0, 8'h04, 10'd80, 10'd340, 10'd40);   // held key is not a new press
    frame(1'b0, 8'h00, 10'd80, 10'd350, 10'd40);
    frame(1'b0, 8'h00, 10'd80, 10'd400, 10'd40);
    frame(1'b0, 8'h00, 10'd80, 10'd440, 10'd40);   // leaves window, already hit
    for (int i = 0; i < 6; i++) frame(1'b0, 8'h00, 10'd80, 10'd0, 10'd40);

    // Lane 2 tile passes through untouched: one miss when bottom reaches 480
    frame(1'b0, 8'h00, 10'd400, 10'd300, 10'd40);
    frame(1'b0, 8'h00, 10'd400, 10'd320, 10'd40);
    frame(1'b0, 8'h00, 10'd400, 10'd400, 10'd40);
    frame(1'b0, 8'h00, 10'd400, 10'd439, 10'd40);
    miss_frame(8'h00, 10'd400, 10'd440, 10'd40);
    frame(1'b0, 8'h00, 10'd400, 10'd460, 10'd40);

    // Wrong lane key, then a non-lane key, then the right key on the same tile
    frame(1'b0, 8'h00, 10'd80, 10'd300, 10'd40);
    frame(1'b0, 8'h00, 10'd80, 10'd330, 10'd40);
`ifdef JUDGE_WRONG_KEY_PENALTY_EN
    miss_frame(8'h07, 10'd80, 10'd340, 10'd40);
`else
    frame(1'b0, 8'h07, 10'd80, 10'd340, 10'd40);
`endif
    frame(1'b0, 8'h07, 10'd80, 10'd345, 10'd40);
    frame(1'b0, 8'h2c, 10'd80, 10'd352, 10'd40);
    hit_frame(8'h04, 10'd80, 10'd355, 10'd40);
    frame(1'b0, 8'h00, 10'd80, 10'd0, 10'd40);

    // Hits up to 99, then the carry into the hundreds digit
    while (e_dec < 99) begin
      frame(1'b0, 8'h00, 10'd80, 10'd300, 10'd40);
      hit_frame(8'h04, 10'd80, 10'd330, 10'd40);
    end
    frame(1'b0, 8'h00, 10'd80, 10'd300, 10'd40);
    hit_frame(8'h04, 10'd80, 10'd330, 10'd40);     // 0x0100

    // Up to 9999, then one more hit must saturate
    while (e_dec < 10000) begin
      frame(1'b0, 8'h00, 10'd80, 10'd300, 10'd40);
      hit_frame(8'h04, 10'd80, 10'd330, 10'd40);
    end

    // Exit misses until the game ends
    for (int g = 0; g < 4 && !e_over; g++) begin
      frame(1'b0, 8'h00, 10'd80, 10'd300, 10'd40);
      frame(1'b0, 8'h00, 10'd80, 10'd330, 10'd40);
      frame(1'b0, 8'h00, 10'd80, 10'd400, 10'd40);
      miss_frame(8'h00, 10'd80, 10'd440, 10'd40);
    end

    // Game over: presses and tile movement change nothing, lane frozen
    frame(1'b0, 8'h09, 10'd600, 10'd300, 10'd40);
    frame(1'b0, 8'h00, 10'd600, 10'd330, 10'd40);
    frame(1'b0, 8'h09, 10'd600, 10'd340, 10'd40);
    frame(1'b0, 8'h16, 10'd600, 10'd450, 10'd40);

    frame(1'b1, 8'h04, 10'd600, 10'd330, 10'd40);
    frame(1'b0, 8'h00, 10'd600, 10'd0, 10'd40);

    // Reset in the same frame as a would-be hit wins
    frame(1'b0, 8'h09, 10'd600, 10'd0, 10'd40);
    frame(1'b0, 8'h00, 10'd600, 10'd320, 10'd40);
    frame(1'b1, 8'h09, 10'd600, 10'd330, 10'd40);
    frame(1'b0, 8'h00, 10'd600, 10'd340, 10'd40);

    @(posedge frame_clk);
    @(posedge frame_clk);
    #2;
    check("queue_drained", 16'(exp_q.size()), 16'd0, frame_no);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
